muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_sequencer_if.sv | 27 ++
 rtl/muldiv_datapath.sv | 78 +++++++
 rtl/muldiv_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared decode constants, FSM state encoding and small helpers for the
// HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_start_fn(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_read_fn(input logic [5:0] f);
    return (f == FN_MFHI) || (f == FN_MFLO);
  endfunction

  function automatic logic is_write_fn(input logic [5:0] f);
    return (f == FN_MTHI) || (f == FN_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage instruction bus and HI/LO result/stall signals between the
// pipeline (master) and the multiply/divide sequencer (slave).
interface muldiv_sequencer_if #(parameter int WIDTH = 32);

  logic             valid_ex;
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             stall;
  logic             busy;
  logic             mf_valid;
  logic [WIDTH-1:0] mf_result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output valid_ex, opcode, func, d1, d2,
    input  stall, busy, mf_valid, mf_result, hi, lo
  );

  modport slave (
    input  valid_ex, opcode, func, d1, d2,
    output stall, busy, mf_valid, mf_result, hi, lo
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Iterative radix-2 shift-add multiplier / restoring divider step logic.
// The quotient shares the low half of the accumulator with the multiplier.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic               div_zero,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   rem
);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   quo_sh_s;

  // One iteration: add-then-shift for multiply, shift-then-trial-subtract for divide.
  always_comb begin
    sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
              + (acc_r[0] ? {1'b0, opnd_r} : (WIDTH+1)'(0));
    rem_sh_s  = {rem_r, acc_r[WIDTH-1]};
    quo_sh_s  = {acc_r[WIDTH-2:0], 1'b0};
    trial_s   = rem_sh_s - {1'b0, opnd_r};
    acc_nxt_s = acc_r;
    rem_nxt_s = rem_r;
    if (is_div) begin
      if (!trial_s[WIDTH]) begin
        rem_nxt_s = trial_s[WIDTH-1:0];
        acc_nxt_s = {WIDTH'(0), quo_sh_s[WIDTH-1:1], 1'b1};
      end else begin
        rem_nxt_s = rem_sh_s[WIDTH-1:0];
        acc_nxt_s = {WIDTH'(0), quo_sh_s};
      end
    end else begin
      acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
      rem_nxt_s = rem_r;
    end
  end

  // Operand load on acceptance, then one step per CALC cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r  <= (2*WIDTH)'(0);
      rem_r  <= WIDTH'(0);
      opnd_r <= WIDTH'(0);
    end else if (load) begin
      if (is_div) begin
        opnd_r <= b;
        acc_r  <= {WIDTH'(0), (div_zero ? {WIDTH{1'b1}} : a)};
        rem_r  <= div_zero ? a : WIDTH'(0);
      end else begin
        opnd_r <= a;
        acc_r  <= {WIDTH'(0), b};
        rem_r  <= WIDTH'(0);
      end
    end else if (step) begin
      acc_r <= acc_nxt_s;
      rem_r <= rem_nxt_s;
    end
  end

  assign acc = acc_r;
  assign rem = rem_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide controller: decodes the EX instruction, sequences the
// datapath, applies sign correction, owns HI/LO and raises the pipeline stall.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clock,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               is_div_r;
  logic               neg_quo_r;
  logic               neg_rem_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               rtype_s;
  logic               start_s;
  logic               read_s;
  logic               write_s;
  logic               accept_s;
  logic               signed_s;
  logic               div_op_s;
  logic               div_zero_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [2*WIDTH-1:0] acc_s;
  logic [WIDTH-1:0]   rem_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // Instruction decode and operand magnitudes.
  always_comb begin
    rtype_s    = bus.valid_ex && (bus.opcode == OP_RTYPE);
    start_s    = rtype_s && is_start_fn(bus.func);
    read_s     = rtype_s && is_read_fn(bus.func);
    write_s    = rtype_s && is_write_fn(bus.func);
    accept_s   = (state_r == ST_IDLE) && start_s;
    signed_s   = (bus.func == FN_MULT) || (bus.func == FN_DIV);
    div_op_s   = (bus.func == FN_DIV) || (bus.func == FN_DIVU);
    div_zero_s = div_op_s && (bus.d2 == WIDTH'(0));
    mag_a_s    = (signed_s && bus.d1[WIDTH-1]) ? (~bus.d1 + WIDTH'(1)) : bus.d1;
    mag_b_s    = (signed_s && bus.d2[WIDTH-1]) ? (~bus.d2 + WIDTH'(1)) : bus.d2;
  end

  // Divide-by-zero hands the raw dividend to HI, so it bypasses the magnitude.
  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .load     (accept_s),
    .step     (state_r == ST_CALC),
    .is_div   (accept_s ? div_op_s : is_div_r),
    .div_zero (div_zero_s),
    .a        (div_zero_s ? bus.d1 : mag_a_s),
    .b        (mag_b_s),
    .acc      (acc_s),
    .rem      (rem_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = div_zero_s ? ST_FIX : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CW'(1)) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, iteration counter and sign flags captured at acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CW'(0);
      busy_r    <= 1'b0;
      is_div_r  <= 1'b0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      if (accept_s) begin
        cnt_r     <= CW'(WIDTH);
        is_div_r  <= div_op_s;
        neg_quo_r <= signed_s && !div_zero_s && (bus.d1[WIDTH-1] ^ bus.d2[WIDTH-1]);
        neg_rem_r <= signed_s && !div_zero_s && bus.d1[WIDTH-1];
      end else if (state_r == ST_CALC) begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  // Sign correction of the unsigned-magnitude results.
  always_comb begin
    prod_fix_s = neg_quo_r ? (~acc_s + (2*WIDTH)'(1)) : acc_s;
    quo_fix_s  = neg_quo_r ? (~acc_s[WIDTH-1:0] + WIDTH'(1)) : acc_s[WIDTH-1:0];
    rem_fix_s  = neg_rem_r ? (~rem_s + WIDTH'(1)) : rem_s;
  end

  // HI/LO: written by FIX, or by mthi/mtlo when idle (never both in one cycle).
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_r <= WIDTH'(0);
      lo_r <= WIDTH'(0);
    end else if (state_r == ST_FIX) begin
      hi_r <= is_div_r ? rem_fix_s : prod_fix_s[2*WIDTH-1:WIDTH];
      lo_r <= is_div_r ? quo_fix_s : prod_fix_s[WIDTH-1:0];
    end else if (!busy_r && write_s) begin
      if (bus.func == FN_MTHI) begin
        hi_r <= bus.d1;
      end else begin
        lo_r <= bus.d1;
      end
    end
  end

  // Interlock and same-cycle HI/LO read port.
  always_comb begin
    bus.busy      = busy_r;
    bus.hi        = hi_r;
    bus.lo        = lo_r;
    bus.stall     = !reset && busy_r && (start_s || read_s || write_s);
    bus.mf_valid  = !reset && !busy_r && read_s;
    bus.mf_result = WIDTH'(0);
    if (bus.mf_valid) begin
      bus.mf_result = (bus.func == FN_MFHI) ? hi_r : lo_r;
    end else begin
      bus.mf_result = WIDTH'(0);
    end
  end

endmodule
